// File: rtl/wt_mem_responder.sv
// Write-through memory responder: buffers cache requests in a small FIFO and
// serves them in order (LOAD, STORE, AMO_SWAP, AMO_ADD) against 128-bit lines.
module wt_mem_responder #(
    parameter int unsigned NumLines    = 64,
    parameter int unsigned TidWidth    = 2,
    parameter int unsigned RespLatency = 0,
    parameter int unsigned FifoDepth   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    output logic                ack_o,
    input  logic [1:0]          req_rtype_i,
    input  logic [TidWidth-1:0] req_tid_i,
    input  logic [31:0]         req_paddr_i,
    input  logic [63:0]         req_data_i,
    input  logic [7:0]          req_be_i,
    output logic                rtrn_vld_o,
    output logic [1:0]          rtrn_rtype_o,
    output logic [TidWidth-1:0] rtrn_tid_o,
    output logic [127:0]        rtrn_data_o,
    output logic                busy_o
);

    localparam int unsigned IdxW = $clog2(NumLines);
    localparam int unsigned PtrW = $clog2(FifoDepth);

    localparam logic [1:0] REQ_LOAD  = 2'd0;
    localparam logic [1:0] REQ_STORE = 2'd1;
    localparam logic [1:0] REQ_SWAP  = 2'd2;
    localparam logic [1:0] REQ_ADD   = 2'd3;

    localparam logic [1:0] ACK_LOAD  = 2'd0;
    localparam logic [1:0] ACK_STORE = 2'd1;
    localparam logic [1:0] ACK_AMO   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]          rtype;
        logic [TidWidth-1:0] tid;
        logic [IdxW-1:0]     idx;
        logic                half;
        logic [63:0]         data;
        logic [7:0]          be;
    } req_t;

    req_t                fifo_q [FifoDepth];
    logic [127:0]        mem_q  [NumLines];

    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]       count_q, count_d;
    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    req_t                cur_q, cur_d;
    logic                rtrn_vld_q, rtrn_vld_d;
    logic [1:0]          rtrn_rtype_q, rtrn_rtype_d;
    logic [TidWidth-1:0] rtrn_tid_q, rtrn_tid_d;
    logic [127:0]        rtrn_data_q, rtrn_data_d;

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                push_s;
    logic                pop_s;
    req_t                req_in_s;
    logic [127:0]        old_line_s;
    logic [63:0]         old_half_s;
    logic [63:0]         new_half_s;
    logic [127:0]        mem_wline_s;
    logic                mem_we_s;
    logic                unused_paddr_s;

    assign fifo_full_s  = (count_q == (PtrW + 1)'(FifoDepth));
    assign fifo_empty_s = (count_q == '0);
    assign ack_o        = !fifo_full_s;
    assign push_s       = req_i & ack_o;
    // Pop decision uses the pre-push count, so a fresh entry waits one cycle.
    assign pop_s        = (state_q == ST_IDLE) & !fifo_empty_s;

    assign req_in_s.rtype = req_rtype_i;
    assign req_in_s.tid   = req_tid_i;
    assign req_in_s.idx   = req_paddr_i[4 +: IdxW];
    assign req_in_s.half  = req_paddr_i[3];
    assign req_in_s.data  = req_data_i;
    assign req_in_s.be    = req_be_i;
    assign unused_paddr_s = ^{req_paddr_i[31:4+IdxW], req_paddr_i[2:0]};

    assign old_line_s = mem_q[cur_q.idx];
    assign old_half_s = cur_q.half ? old_line_s[127:64] : old_line_s[63:0];

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer: IDLE -> (WAIT) -> EXEC -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    cur_d = fifo_q[rd_ptr_q];
                    if (RespLatency > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(RespLatency);
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_EXEC;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operation datapath and response formation
    always_comb begin
        new_half_s   = old_half_s;
        mem_we_s     = 1'b0;
        rtrn_vld_d   = 1'b0;
        rtrn_rtype_d = rtrn_rtype_q;
        rtrn_tid_d   = rtrn_tid_q;
        rtrn_data_d  = rtrn_data_q;
        if (state_q == ST_EXEC) begin
            rtrn_vld_d = 1'b1;
            rtrn_tid_d = cur_q.tid;
            case (cur_q.rtype)
                REQ_LOAD: begin
                    rtrn_rtype_d = ACK_LOAD;
                    rtrn_data_d  = old_line_s;
                end
                REQ_STORE: begin
                    for (int b = 0; b < 8; b++) begin
                        if (cur_q.be[b]) begin
                            new_half_s[8*b +: 8] = cur_q.data[8*b +: 8];
                        end else begin
                            new_half_s[8*b +: 8] = old_half_s[8*b +: 8];
                        end
                    end
                    mem_we_s     = |cur_q.be;
                    rtrn_rtype_d = ACK_STORE;
                    rtrn_data_d  = 128'd0;
                end
                REQ_SWAP: begin
                    new_half_s   = cur_q.data;
                    mem_we_s     = 1'b1;
                    rtrn_rtype_d = ACK_AMO;
                    rtrn_data_d  = {old_half_s, old_half_s};
                end
                REQ_ADD: begin
                    new_half_s   = old_half_s + cur_q.data;
                    mem_we_s     = 1'b1;
                    rtrn_rtype_d = ACK_AMO;
                    rtrn_data_d  = {old_half_s, old_half_s};
                end
                default: begin
                    rtrn_rtype_d = ACK_LOAD;
                    rtrn_data_d  = 128'd0;
                end
            endcase
        end else begin
            rtrn_vld_d = 1'b0;
        end
    end

    assign mem_wline_s = cur_q.half ? {new_half_s, old_line_s[63:0]}
                                    : {old_line_s[127:64], new_half_s};

    // Control and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            cur_q        <= '0;
            rtrn_vld_q   <= 1'b0;
            rtrn_rtype_q <= 2'd0;
            rtrn_tid_q   <= '0;
            rtrn_data_q  <= 128'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            rtrn_vld_q   <= rtrn_vld_d;
            rtrn_rtype_q <= rtrn_rtype_d;
            rtrn_tid_q   <= rtrn_tid_d;
            rtrn_data_q  <= rtrn_data_d;
        end
    end

    // Request FIFO storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_s) begin
            fifo_q[wr_ptr_q] <= req_in_s;
        end
    end

    // Line storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumLines; i++) begin
                mem_q[i] <= 128'd0;
            end
        end else if (mem_we_s) begin
            mem_q[cur_q.idx] <= mem_wline_s;
        end
    end

    assign rtrn_vld_o   = rtrn_vld_q;
    assign rtrn_rtype_o = rtrn_rtype_q;
    assign rtrn_tid_o   = rtrn_tid_q;
    assign rtrn_data_o  = rtrn_data_q;
    assign busy_o       = !fifo_empty_s | (state_q != ST_IDLE);

endmodule

// File: tb/tb_wt_mem_responder.sv
// Scoreboard bench for wt_mem_responder: a zero-latency instance for function
// and ordering, and a RespLatency=3 instance for wait timing and reset abort.
module tb_wt_mem_responder;

    localparam int NL = 64;

    logic         clk = 1'b0;
    logic         rst0, rst1, req0, req1;
    logic [1:0]   rtype, tid;
    logic [31:0]  paddr;
    logic [63:0]  wdata;
    logic [7:0]   be;

    logic         ack0, vld0, busy0, ack1, vld1, busy1;
    logic [1:0]   rrtype0, rtid0, rrtype1, rtid1;
    logic [127:0] rdata0, rdata1;

    typedef struct {
        logic [1:0]   rtype;
        logic [1:0]   tid;
        logic [127:0] data;
        int           t;
        bit           chk_lat;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] mdl[NL];
    int           n_checks = 0;
    int           n_err    = 0;
    int           cyc      = 0;
    int           vld0_cnt = 0;
    int           drops    = 0;
    bit           lat_chk  = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wt_mem_responder #(.RespLatency(0)) dut0 (
        .clk_i(clk), .rst_i(rst0), .req_i(req0), .ack_o(ack0),
        .req_rtype_i(rtype), .req_tid_i(tid), .req_paddr_i(paddr),
        .req_data_i(wdata), .req_be_i(be), .rtrn_vld_o(vld0),
        .rtrn_rtype_o(rrtype0), .rtrn_tid_o(rtid0), .rtrn_data_o(rdata0),
        .busy_o(busy0)
    );

    wt_mem_responder #(.RespLatency(3)) dut1 (
        .clk_i(clk), .rst_i(rst1), .req_i(req1), .ack_o(ack1),
        .req_rtype_i(rtype), .req_tid_i(tid), .req_paddr_i(paddr),
        .req_data_i(wdata), .req_be_i(be), .rtrn_vld_o(vld1),
        .rtrn_rtype_o(rrtype1), .rtrn_tid_o(rtid1), .rtrn_data_o(rdata1),
        .busy_o(busy1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour applied at acceptance time (completion is in order)
    task automatic model_push(input logic [1:0] rt, input logic [1:0] t, input logic [31:0] a,
                              input logic [63:0] d, input logic [7:0] b);
        exp_t         e;
        int           idx;
        logic [127:0] line;
        logic [63:0]  old, nh;
        idx  = int'((a >> 4) & (NL - 1));
        line = mdl[idx];
        old  = a[3] ? line[127:64] : line[63:0];
        nh   = old;
        e.tid = t;
        e.t = cyc;
        e.chk_lat = lat_chk;
        case (rt)
            2'd0: begin e.rtype = 2'd0; e.data = line; end
            2'd1: begin
                for (int k = 0; k < 8; k++) if (b[k]) nh[8*k +: 8] = d[8*k +: 8];
                e.rtype = 2'd1; e.data = 128'd0;
            end
            2'd2: begin nh = d; e.rtype = 2'd2; e.data = {old, old}; end
            default: begin nh = old + d; e.rtype = 2'd2; e.data = {old, old}; end
        endcase
        if (a[3]) line[127:64] = nh; else line[63:0] = nh;
        mdl[idx] = line;
        sb.push_back(e);
    endtask

    task automatic send0(input logic [1:0] rt, input logic [1:0] t, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] b);
        int k;
        @(negedge clk);
        rtype = rt; tid = t; paddr = a; wdata = d; be = b; req0 = 1'b1;
        k = 0;
        while (ack0 !== 1'b1 && k < 50) begin
            drops++;
            @(negedge clk);
            k++;
        end
        if (ack0 !== 1'b1) check("ack_timeout", ack0, 1'b1);
        else model_push(rt, t, a, d, b);
    endtask

    task automatic drain0();
        @(negedge clk);
        req0 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && busy0 === 1'b0) break;
            @(posedge clk);
            #1;
        end
        check("drain_sb", sb.size(), 0);
        check("drain_busy", busy0, 1'b0);
    endtask

    task automatic single0(input logic [1:0] rt, input logic [1:0] t, input logic [31:0] a,
                           input logic [63:0] d, input logic [7:0] b);
        send0(rt, t, a, d, b);
        drain0();
    endtask

    // Response monitor for the zero-latency instance
    always @(negedge clk) begin
        exp_t e;
        if (vld0 === 1'b1) begin
            vld0_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_rtrn", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("rtrn_rtype", rrtype0, e.rtype);
                check("rtrn_tid", rtid0, e.tid);
                check("rtrn_data", rdata0, e.data);
                if (e.chk_lat) check("latency", cyc, e.t + 3);
            end
        end
    end

    initial begin
        int t0, got_t, base, cnt;
        logic [127:0] got_d;
        logic [1:0]   got_rt, got_tid;
        rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
        rtype = 2'd0; tid = 2'd0; paddr = 32'd0; wdata = 64'd0; be = 8'd0;
        for (int i = 0; i < NL; i++) mdl[i] = 128'd0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check("rst_vld", vld0, 1'b0);
        check("rst_rtype", rrtype0, 2'd0);
        check("rst_tid", rtid0, 2'd0);
        check("rst_data", rdata0, 128'd0);
        check("rst_busy", busy0, 1'b0);
        check("rst_ack", ack0, 1'b1);

        single0(2'd0, 2'd1, 32'h40, 64'd0, 8'h00);
        single0(2'd1, 2'd2, 32'h48, 64'h1122334455667788, 8'h0F);
        single0(2'd0, 2'd3, 32'h40, 64'd0, 8'h00);
        single0(2'd2, 2'd0, 32'h40, 64'd1, 8'h00);
        single0(2'd3, 2'd1, 32'h40, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        single0(2'd0, 2'd2, 32'h40, 64'd0, 8'h00);
        single0(2'd1, 2'd3, 32'h48, 64'hDEADBEEFCAFEF00D, 8'h00);
        single0(2'd0, 2'd0, 32'h10000C4D, 64'd0, 8'h00);
        single0(2'd2, 2'd1, 32'h7F8, 64'hA5A5A5A5A5A5A5A5, 8'h00);
        single0(2'd0, 2'd2, 32'h3F0, 64'd0, 8'h00);

        // Back-to-back burst fills the FIFO
        lat_chk = 1'b0; drops = 0; base = vld0_cnt;
        for (int i = 0; i < 8; i++) begin
            send0(2'($urandom_range(0, 3)), 2'(i % 4),
                  32'($urandom_range(0, 3) << 4) | (32'($urandom_range(0, 1)) << 3),
                  {$urandom, $urandom}, 8'($urandom));
            if (i == 3) check("busy_in_burst", busy0, 1'b1);
        end
        drain0();
        check("ack_dropped", drops > 0, 1'b1);
        check("burst_count", vld0_cnt - base, 8);
        lat_chk = 1'b1;

        // Reset with work queued and in flight: nothing may come out
        send0(2'd1, 2'd0, 32'h48, 64'h0123456789ABCDEF, 8'hFF);
        send0(2'd0, 2'd1, 32'h48, 64'd0, 8'h00);
        @(posedge clk);
        #1;
        rst0 = 1'b1; req0 = 1'b0;
        sb.delete();
        for (int i = 0; i < NL; i++) mdl[i] = 128'd0;
        base = vld0_cnt;
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_rtrn", vld0_cnt - base, 0);
        check("abort_busy", busy0, 1'b0);
        check("abort_ack", ack0, 1'b1);
        single0(2'd0, 2'd3, 32'h40, 64'd0, 8'h00);

        // RespLatency=3 instance: timing, then reset during WAIT
        @(negedge clk);
        rtype = 2'd0; tid = 2'd1; paddr = 32'h40; req1 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        req1 = 1'b0;
        got_t = -1; got_d = '1; got_rt = 2'd3; got_tid = 2'd0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (vld1 === 1'b1) begin
                got_t = cyc; got_d = rdata1; got_rt = rrtype1; got_tid = rtid1;
                break;
            end
        end
        check("lat3_cycle", got_t, t0 + 6);
        check("lat3_rtype", got_rt, 2'd0);
        check("lat3_tid", got_tid, 2'd1);
        check("lat3_data", got_d, 128'd0);
        @(negedge clk);
        check("lat3_busy", busy1, 1'b0);
        rtype = 2'd1; tid = 2'd2; paddr = 32'h48; wdata = 64'hFFFF; be = 8'hFF; req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        check("lat3_busy_wait", busy1, 1'b1);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vld1 === 1'b1) cnt++;
        end
        check("wait_abort_rtrn", cnt, 0);
        check("wait_abort_busy", busy1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wt_mem_responder.md
WT_MEM_RESPONDER -- requirements
Module: wt_mem_responder

Interface
- REQ-001: Parameter NumLines, default 64, number of 128-bit lines in internal storage (power of two).
- REQ-002: Parameter TidWidth, default 2, transaction-ID width.
- REQ-003: Parameter RespLatency, default 0, extra wait cycles inserted before each execution (0..15).
- REQ-004: Parameter FifoDepth, default 4, request FIFO entries (power of two, >=2).
- REQ-005: clk_i  input  1  single clock; all state on rising edge.
- REQ-006: rst_i  input  1  reset, asynchronous assert, active-high.
- REQ-007: req_i  input  1  cache request valid (data_req).
- REQ-008: ack_o  output  1  request accepted this cycle when req_i&ack_o.
- REQ-009: req_rtype_i  input  2  0=LOAD, 1=STORE, 2=AMO_SWAP, 3=AMO_ADD.
- REQ-010: req_tid_i  input  TidWidth  transaction ID.
- REQ-011: req_paddr_i  input  32  physical byte address.
- REQ-012: req_data_i  input  64  store/AMO operand.
- REQ-013: req_be_i  input  8  store byte enables.
- REQ-014: rtrn_vld_o  output  1  response valid, single cycle, no backpressure.
- REQ-015: rtrn_rtype_o  output  2  0=LOAD_ACK, 1=STORE_ACK, 2=AMO_ACK.
- REQ-016: rtrn_tid_o  output  TidWidth  echoed request ID.
- REQ-017: rtrn_data_o  output  128  response payload.
- REQ-018: busy_o  output  1  FIFO non-empty or FSM not IDLE.

Function
- REQ-019: Line index SHALL be paddr[4 +: log2(NumLines)]; paddr[3] SHALL select the 64-bit half (1=upper); paddr[2:0] and upper bits SHALL be ignored.
- REQ-020: ack_o SHALL be combinational !fifo_full; a request SHALL be pushed on req_i&ack_o; when full, ack_o=0 even if a pop occurs that cycle.
- REQ-021: FSM states IDLE, WAIT, EXEC; IDLE with FIFO non-empty SHALL pop the head and go to WAIT (counter loaded with RespLatency) if RespLatency>0, else EXEC.
- REQ-022: WAIT SHALL decrement the counter each cycle and go to EXEC in the cycle after the counter reaches 1.
- REQ-023: EXEC SHALL perform the operation at its closing edge, register the response, and return to IDLE.
- REQ-024: rtrn_vld_o SHALL be registered and high exactly the cycle after EXEC, for one cycle.
- REQ-025: Latency: request accepted in cycle T into an empty FIFO with FSM IDLE SHALL produce rtrn_vld_o in cycle T+3+RespLatency.
- REQ-026: LOAD: rtrn_data_o = addressed line; rtype LOAD_ACK; storage unchanged.
- REQ-027: STORE: bytes of the selected half with req_be_i set SHALL be written from req_data_i; rtype STORE_ACK; rtrn_data_o = 0; be=0 SHALL still ack with no write.
- REQ-028: AMO_SWAP writes req_data_i to the selected half; AMO_ADD writes old+req_data_i modulo 2^64; both ignore req_be_i, rtype AMO_ACK, rtrn_data_o = {old, old}.
- REQ-029: Requests SHALL complete strictly in acceptance order; a response SHALL observe all earlier writes.
- REQ-030: Push into an empty FIFO and pop in the same cycle SHALL not occur (pop sees pre-push state); push and pop on a non-full FIFO in the same cycle SHALL keep count unchanged.
- REQ-031: FIFO pointers SHALL wrap modulo FifoDepth.

Reset
- REQ-032: On rst_i: FSM=IDLE, FIFO empty, counter=0, rtrn_vld_o=0, rtrn_rtype_o=0, rtrn_tid_o=0, rtrn_data_o=0, busy_o=0, ack_o=1 after release, all storage lines zero.
- REQ-033: Reset asserted mid-operation SHALL discard queued and in-flight requests; no response SHALL be emitted for them.

Verification
- REQ-034: After reset, LOAD paddr 0x40 tid 1 at cycle T -> rtrn_vld_o at T+3, LOAD_ACK, tid 1, data 0.
- REQ-035: STORE paddr 0x48 data 0x1122334455667788 be 0x0F, then LOAD 0x40 -> STORE_ACK then data upper half 0x0000000055667788, lower 0.
- REQ-036: AMO_ADD paddr 0x40 operand 0xFFFFFFFFFFFFFFFF onto 0x1 -> AMO_ACK data {0x1,0x1}; subsequent LOAD lower half 0x0.
- REQ-037: Hold req_i for 8 back-to-back requests tids 0..3 repeating -> ack_o drops after FIFO full, responses in order, none lost, busy_o falls after last rtrn.
- REQ-038: RespLatency=3, single LOAD -> rtrn_vld_o at T+6; assert rst_i during WAIT -> no rtrn_vld_o, busy_o=0.
